// File: rtl/stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1xn
// Description : Registered 1-to-N valid/ready stream demultiplexer with
//               packet-lock routing and saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1xn #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [SW-1:0]   in_sel,
    output logic [N*W-1:0]  out_data,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [N-1:0]    out_last,
    output logic [CW-1:0]   drop_cnt,
    output logic            busy
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_lock = 1'b1;

    logic [0:0]     r_state;
    logic [0:0]     w_state_next;
    logic [SW-1:0]  r_lock_sel;
    logic [SW-1:0]  w_lock_sel_next;
    logic [SW-1:0]  w_tgt;
    logic           w_tgt_ok;
    logic           w_ready;
    logic           w_accept;
    logic [N-1:0]   r_out_valid;
    logic [N*W-1:0] r_out_data;
    logic [N-1:0]   r_out_last;
    logic [CW-1:0]  r_drop_cnt;

    // in_sel only matters on the first beat; mid-packet the locked channel wins.
    assign w_tgt = (r_state == c_st_idle) ? in_sel : r_lock_sel;

    generate
        if ((1 << SW) == N) begin : g_pow2
            assign w_tgt_ok = 1'b1;
        end else begin : g_npow2
            localparam logic [SW:0] c_n_ext = (SW+1)'(N);
            assign w_tgt_ok = ({1'b0, w_tgt} < c_n_ext);
        end
    endgenerate

    // Out-of-range targets match no channel, so they are always ready and dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (w_tgt == SW'(k)) begin
                w_ready = ~r_out_valid[k] | out_ready[k];
            end
        end
    end

    assign w_accept = in_valid & w_ready;

    always_comb begin
        w_state_next    = r_state;
        w_lock_sel_next = r_lock_sel;
        case (r_state)
            c_st_idle: begin
                if (w_accept && !in_last) begin
                    w_state_next    = c_st_lock;
                    w_lock_sel_next = in_sel;
                end
            end
            c_st_lock: begin
                if (w_accept && in_last) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_lock_sel <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_sel <= w_lock_sel_next;
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_chan
            logic w_load;
            assign w_load = w_accept & w_tgt_ok & (w_tgt == SW'(k));

            // A load in the same cycle as a drain keeps valid high for full throughput.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_valid[k]       <= 1'b0;
                    r_out_data[k*W +: W] <= '0;
                    r_out_last[k]        <= 1'b0;
                end else if (w_load) begin
                    r_out_valid[k]       <= 1'b1;
                    r_out_data[k*W +: W] <= in_data;
                    r_out_last[k]        <= in_last;
                end else if (out_ready[k]) begin
                    r_out_valid[k]       <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_tgt_ok && (r_drop_cnt != {CW{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + CW'(1);
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign drop_cnt  = r_drop_cnt;
    assign busy      = (r_state == c_st_lock);

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1xn
// Description : Bench for stream_demux_1xn; drives an N=4 and an N=3/CW=2
//               instance from one stimulus stream against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1xn;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  in_sel;
    logic [3:0]  out_ready;

    logic        rdy4, busy4;
    logic [31:0] od4;
    logic [3:0]  ov4, ol4;
    logic [7:0]  dc4;

    logic        rdy3, busy3;
    logic [23:0] od3;
    logic [2:0]  ov3, ol3;
    logic [1:0]  dc3;

    int errors = 0;
    int checks = 0;

    stream_demux_1xn #(.W(8), .N(4), .CW(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy4), .in_last(in_last), .in_sel(in_sel),
        .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
        .out_last(ol4), .drop_cnt(dc4), .busy(busy4)
    );

    stream_demux_1xn #(.W(8), .N(3), .CW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy3), .in_last(in_last), .in_sel(in_sel),
        .out_data(od3), .out_valid(ov3), .out_ready(out_ready[2:0]),
        .out_last(ol3), .drop_cnt(dc3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel holds at most one pending beat; index 0 = N4, 1 = N3.
    int         n_of[2]   = '{4, 3};
    int         dmax[2]   = '{255, 3};
    bit         m_full[2][4];
    logic [7:0] m_data[2][4];
    bit         m_last[2][4];
    bit         m_lock[2];
    int         m_lsel[2];
    int         m_drop[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) begin
                m_full[m][c] = 1'b0;
                m_data[m][c] = 8'h00;
                m_last[m][c] = 1'b0;
            end
            m_lock[m] = 1'b0;
            m_lsel[m] = 0;
            m_drop[m] = 0;
        end
    endtask

    function automatic int tgt_of(int m);
        return m_lock[m] ? m_lsel[m] : int'(in_sel);
    endfunction

    function automatic bit exp_ready(int m);
        int t;
        t = tgt_of(m);
        if (t >= n_of[m]) return 1'b1;
        return !m_full[m][t] || out_ready[t];
    endfunction

    task automatic model_clock();
        for (int m = 0; m < 2; m++) begin
            bit acc;
            int t;
            t   = tgt_of(m);
            acc = in_valid && exp_ready(m);
            for (int c = 0; c < n_of[m]; c++)
                if (m_full[m][c] && out_ready[c]) m_full[m][c] = 1'b0;
            if (acc) begin
                if (t >= n_of[m]) begin
                    if (m_drop[m] < dmax[m]) m_drop[m]++;
                end else begin
                    m_full[m][t] = 1'b1;
                    m_data[m][t] = in_data;
                    m_last[m][t] = in_last;
                end
                if (in_last) m_lock[m] = 1'b0;
                else if (!m_lock[m]) begin
                    m_lock[m] = 1'b1;
                    m_lsel[m] = int'(in_sel);
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            logic [63:0] ev, ed, el;
            ev = '0; ed = '0; el = '0;
            for (int c = 0; c < n_of[m]; c++) begin
                ev[c]       = m_full[m][c];
                ed[c*8 +: 8] = m_data[m][c];
                el[c]       = m_last[m][c];
            end
            if (m == 0) begin
                chk("ov4", 64'(ov4), ev);
                chk("od4", 64'(od4), ed);
                chk("ol4", 64'(ol4), el);
                chk("dc4", 64'(dc4), 64'(m_drop[0]));
                chk("busy4", 64'(busy4), 64'(m_lock[0]));
            end else begin
                chk("ov3", 64'(ov3), ev);
                chk("od3", 64'(od3), ed);
                chk("ol3", 64'(ol3), el);
                chk("dc3", 64'(dc3), 64'(m_drop[1]));
                chk("busy3", 64'(busy3), 64'(m_lock[1]));
            end
        end
    endtask

    // Inputs are set just after a rising edge; this checks ready, clocks, and checks outputs.
    task automatic cycle();
        @(negedge clk);
        chk("rdy4", 64'(rdy4), 64'(exp_ready(0)));
        chk("rdy3", 64'(rdy3), 64'(exp_ready(1)));
        @(posedge clk);
        model_clock();
        #1;
        check_outputs();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_ov4", 64'(ov4), 64'h0);
        chk("rst_dc4", 64'(dc4), 64'h0);
        chk("rst_busy4", 64'(busy4), 64'h0);
        chk("rst_ov3", 64'(ov3), 64'h0);
        chk("rst_dc3", 64'(dc3), 64'h0);
        chk("rst_busy3", 64'(busy3), 64'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
        in_valid = v; in_sel = s; in_data = d; in_last = l;
    endtask

    int exp_dc[5] = '{1, 2, 3, 3, 3};

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        out_ready = 4'hF;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Traffic then asynchronous reset mid-stream.
        drive(1'b1, 2'd1, 8'h5A, 1'b0);
        cycle();
        out_ready = 4'h0;
        drive(1'b1, 2'd1, 8'h6B, 1'b0);
        cycle();
        reset_pulse();
        out_ready = 4'hF;

        // Single beat to channel 2.
        drive(1'b1, 2'd2, 8'hA5, 1'b1);
        cycle();
        chk("t2_ov", 64'(ov4), 64'b0100);
        chk("t2_data", 64'(od4[23:16]), 64'hA5);
        chk("t2_last", 64'(ol4[2]), 64'h1);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        cycle();
        chk("t2_drain", 64'(ov4), 64'h0);

        // Packet lock: select changes mid-packet are ignored.
        drive(1'b1, 2'd1, 8'h11, 1'b0);
        cycle();
        chk("t3_busy1", 64'(busy4), 64'h1);
        chk("t3_ov1", 64'(ov4), 64'b0010);
        drive(1'b1, 2'd3, 8'h22, 1'b0);
        cycle();
        chk("t3_busy2", 64'(busy4), 64'h1);
        chk("t3_ov2", 64'(ov4), 64'b0010);
        chk("t3_d2", 64'(od4[15:8]), 64'h22);
        drive(1'b1, 2'd0, 8'h33, 1'b1);
        cycle();
        chk("t3_busy3", 64'(busy4), 64'h0);
        chk("t3_ov3", 64'(ov4), 64'b0010);
        chk("t3_d3", 64'(od4[15:8]), 64'h33);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        cycle();

        // Backpressure on channel 0 does not block channel 2.
        out_ready = 4'b1110;
        drive(1'b1, 2'd0, 8'hB1, 1'b1);
        cycle();
        drive(1'b1, 2'd0, 8'hB2, 1'b1);
        #1;
        chk("t4_stall", 64'(rdy4), 64'h0);
        cycle();
        chk("t4_held", 64'(od4[7:0]), 64'hB1);
        drive(1'b1, 2'd2, 8'hC3, 1'b1);
        #1;
        chk("t4_other", 64'(rdy4), 64'h1);
        cycle();
        out_ready = 4'hF;
        drive(1'b1, 2'd0, 8'hB2, 1'b1);
        #1;
        chk("t4_release", 64'(rdy4), 64'h1);
        cycle();
        chk("t4_ov0", 64'(ov4[0]), 64'h1);
        chk("t4_d0", 64'(od4[7:0]), 64'hB2);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        cycle();

        // Invalid select on the 3-channel instance saturates the 2-bit drop counter.
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd3, 8'(8'h70 + i), 1'b1);
            #1;
            chk("t5_rdy", 64'(rdy3), 64'h1);
            cycle();
            chk("t5_ov", 64'(ov3), 64'h0);
            chk("t5_dc", 64'(dc3), 64'(exp_dc[i]));
        end

        // Reset in the middle of a packet releases the lock.
        drive(1'b1, 2'd1, 8'h55, 1'b0);
        cycle();
        chk("t6_busy", 64'(busy4), 64'h1);
        reset_pulse();
        drive(1'b1, 2'd2, 8'h44, 1'b1);
        cycle();
        chk("t6_ov", 64'(ov4), 64'b0100);
        chk("t6_data", 64'(od4[23:16]), 64'h44);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        cycle();

        // Randomised traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom), ($urandom_range(0, 2) == 0));
            out_ready = 4'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
